// File: rtl/button_event_ctrl.sv
// Front-panel event scheduler: per-button PRESS/LONG/REPEAT/RELEASE detection,
// one-deep pending slots, round-robin arbitration into a shared event FIFO.
module button_event_ctrl #(
   parameter int unsigned NBTN     = 4,
   parameter int unsigned CW       = 24,
   parameter int unsigned LONG_CYC = 25000000,
   parameter int unsigned REP_CYC  = 5000000,
   parameter int unsigned REP_EN   = 1,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NBTN-1:0]        db_level,
   output logic                   ev_valid,
   input  logic                   ev_ready,
   output logic [2:0]             ev_btn,
   output logic [1:0]             ev_type,
   output logic [$clog2(DEPTH):0] ev_count,
   output logic                   ovf
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CNTW = PW + 1;
   localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYC - 1);
   localparam logic [CW-1:0] REP_TC  = CW'(REP_CYC - 1);

   localparam logic [1:0] EV_PRESS   = 2'b00;
   localparam logic [1:0] EV_LONG    = 2'b01;
   localparam logic [1:0] EV_REPEAT  = 2'b10;
   localparam logic [1:0] EV_RELEASE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESSED = 2'd1,
      S_HELD    = 2'd2
   } state_t;

   state_t          st     [NBTN];
   logic [CW-1:0]   cnt    [NBTN];
   logic [1:0]      pend_t [NBTN];
   logic [NBTN-1:0] prev;
   logic [NBTN-1:0] pend_v;

   logic [NBTN-1:0] raise_c;
   logic [1:0]      raise_t_c [NBTN];

   logic [2:0]      rr;
   logic            gnt_v_c;
   logic [2:0]      gnt_i_c;
   logic [1:0]      gnt_t_c;
   logic [NBTN-1:0] gnt_oh_c;
   logic [3:0]      idx_c;
   logic            pop_c;
   logic            push_c;
   logic [4:0]      wdata_c;

   logic [4:0]      mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   rd_ptr_n_c;
   logic [CNTW-1:0] count_n_c;
   logic [4:0]      head_n_c;

   // Event each button would raise this cycle; fall beats a terminal count
   always_comb begin
      for (int i = 0; i < NBTN; i++) begin
         raise_c[i]   = 1'b0;
         raise_t_c[i] = EV_PRESS;
         case (st[i])
            S_IDLE: begin
               if (db_level[i] && !prev[i]) begin
                  raise_c[i]   = 1'b1;
                  raise_t_c[i] = EV_PRESS;
               end
            end
            S_PRESSED: begin
               if (!db_level[i]) begin
                  raise_c[i]   = 1'b1;
                  raise_t_c[i] = EV_RELEASE;
               end else if (cnt[i] == LONG_TC) begin
                  raise_c[i]   = 1'b1;
                  raise_t_c[i] = EV_LONG;
               end
            end
            S_HELD: begin
               if (!db_level[i]) begin
                  raise_c[i]   = 1'b1;
                  raise_t_c[i] = EV_RELEASE;
               end else if (REP_EN != 0 && cnt[i] == REP_TC) begin
                  raise_c[i]   = 1'b1;
                  raise_t_c[i] = EV_REPEAT;
               end
            end
            default: ;
         endcase
      end
   end

   assign pop_c = (ev_count != '0) && ev_ready;

   // Round-robin pick of one pending slot, starting the search at rr
   always_comb begin
      gnt_v_c = 1'b0;
      gnt_i_c = '0;
      gnt_t_c = EV_PRESS;
      idx_c   = '0;
      for (int k = 0; k < NBTN; k++) begin
         idx_c = 4'(rr) + 4'(k);
         if (idx_c >= 4'(NBTN)) idx_c = idx_c - 4'(NBTN);
         for (int i = 0; i < NBTN; i++) begin
            if (!gnt_v_c && pend_v[i] && idx_c == 4'(i)) begin
               gnt_v_c = 1'b1;
               gnt_i_c = 3'(i);
               gnt_t_c = pend_t[i];
            end
         end
      end
      push_c = gnt_v_c && ((ev_count != CNTW'(DEPTH)) || pop_c);
      for (int i = 0; i < NBTN; i++) begin
         gnt_oh_c[i] = push_c && (gnt_i_c == 3'(i));
      end
   end

   // Next FIFO head, forwarding the write when it lands in an otherwise empty queue
   always_comb begin
      wdata_c    = {gnt_i_c, gnt_t_c};
      rd_ptr_n_c = pop_c ? rd_ptr + PW'(1) : rd_ptr;
      count_n_c  = ev_count + CNTW'(push_c) - CNTW'(pop_c);
      head_n_c   = (push_c && wr_ptr == rd_ptr_n_c) ? wdata_c : mem[rd_ptr_n_c];
   end

   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= wdata_c;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NBTN; i++) begin
            st[i]     <= S_IDLE;
            cnt[i]    <= '0;
            pend_t[i] <= EV_PRESS;
         end
         prev     <= '0;
         pend_v   <= '0;
         rr       <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ev_count <= '0;
         ev_valid <= 1'b0;
         ev_btn   <= '0;
         ev_type  <= '0;
         ovf      <= 1'b0;
      end else begin
         prev <= db_level;
         for (int i = 0; i < NBTN; i++) begin
            case (st[i])
               S_IDLE: begin
                  if (db_level[i] && !prev[i]) begin
                     st[i]  <= S_PRESSED;
                     cnt[i] <= '0;
                  end
               end
               S_PRESSED: begin
                  if (!db_level[i]) begin
                     st[i]  <= S_IDLE;
                     cnt[i] <= '0;
                  end else if (cnt[i] == LONG_TC) begin
                     st[i]  <= S_HELD;
                     cnt[i] <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + CW'(1);
                  end
               end
               S_HELD: begin
                  if (!db_level[i]) begin
                     st[i]  <= S_IDLE;
                     cnt[i] <= '0;
                  end else if (REP_EN == 0 || cnt[i] == REP_TC) begin
                     cnt[i] <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + CW'(1);
                  end
               end
               default: begin
                  st[i]  <= S_IDLE;
                  cnt[i] <= '0;
               end
            endcase

            // A slot freed by this edge's grant may take the new event
            if (raise_c[i] && pend_v[i] && !gnt_oh_c[i]) begin
               ovf <= 1'b1;
            end else if (raise_c[i]) begin
               pend_v[i] <= 1'b1;
               pend_t[i] <= raise_t_c[i];
            end else if (gnt_oh_c[i]) begin
               pend_v[i] <= 1'b0;
            end
         end

         if (push_c) begin
            wr_ptr <= wr_ptr + PW'(1);
            rr     <= (gnt_i_c == 3'(NBTN - 1)) ? 3'd0 : gnt_i_c + 3'd1;
         end
         rd_ptr   <= rd_ptr_n_c;
         ev_count <= count_n_c;
         ev_valid <= (count_n_c != '0);
         ev_btn   <= head_n_c[4:2];
         ev_type  <= head_n_c[1:0];
      end
   end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: vector table for tap/contention, hand
// sequences for long hold, overflow drain and reset mid-hold.
module tb_button_event_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] db_level;
   logic       ev_ready;
   logic       ev_valid;
   logic [2:0] ev_btn;
   logic [1:0] ev_type;
   logic [2:0] ev_count;
   logic       ovf;

   logic       nr_ready;
   logic       nr_valid;
   logic [2:0] nr_btn;
   logic [1:0] nr_type;
   logic [2:0] nr_count;
   logic       nr_ovf;

   int checks = 0;
   int errors = 0;

   logic [4:0] q_main [$];
   logic [4:0] q_nr   [$];

   typedef struct packed {
      logic [3:0] db;
      logic       rdy;
      logic       v;
      logic [2:0] btn;
      logic [1:0] typ;
      logic [2:0] cnt;
   } vec_t;

   vec_t tbl [$];

   always #5 clk = ~clk;

   button_event_ctrl #(
      .NBTN(4), .CW(8), .LONG_CYC(8), .REP_CYC(4), .REP_EN(1), .DEPTH(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .db_level(db_level),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_btn(ev_btn),
      .ev_type(ev_type), .ev_count(ev_count), .ovf(ovf)
   );

   button_event_ctrl #(
      .NBTN(4), .CW(8), .LONG_CYC(8), .REP_CYC(4), .REP_EN(0), .DEPTH(4)
   ) dut_nr (
      .clk(clk), .reset_n(reset_n), .db_level(db_level),
      .ev_valid(nr_valid), .ev_ready(nr_ready), .ev_btn(nr_btn),
      .ev_type(nr_type), .ev_count(nr_count), .ovf(nr_ovf)
   );

   // Record every event handed to the consumer of each instance
   always @(negedge clk) begin
      if (ev_valid === 1'b1 && ev_ready === 1'b1) q_main.push_back({ev_btn, ev_type});
      if (nr_valid === 1'b1) q_nr.push_back({nr_btn, nr_type});
   end

   function automatic vec_t mk(input logic [3:0] db, input logic rdy, input logic v,
                               input logic [2:0] btn, input logic [1:0] typ,
                               input logic [2:0] cnt);
      vec_t r;
      r.db = db; r.rdy = rdy; r.v = v; r.btn = btn; r.typ = typ; r.cnt = cnt;
      return r;
   endfunction

   task automatic step(input logic r, input logic [3:0] d, input logic rd);
      @(posedge clk);
      #1;
      reset_n  = r;
      db_level = d;
      ev_ready = rd;
   endtask

   task automatic check_out(input string name, input logic v, input logic [2:0] b,
                            input logic [1:0] t, input logic [2:0] c, input logic o,
                            input logic full);
      logic [9:0] a;
      logic [9:0] e;
      a = {ev_valid, ev_btn, ev_type, ev_count, ovf};
      e = {v, b, t, c, o};
      if (!v && !full) begin
         a[8:4] = '0;
         e[8:4] = '0;
      end
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got v=%b btn=%0d type=%0d count=%0d ovf=%b, want v=%b btn=%0d type=%0d count=%0d ovf=%b",
                  name, a[9], a[8:6], a[5:4], a[3:1], a[0], e[9], e[8:6], e[5:4], e[3:1], e[0]);
      end
   endtask

   task automatic cyc(input string name, input logic r, input logic [3:0] d, input logic rd,
                      input logic v, input logic [2:0] b, input logic [1:0] t,
                      input logic [2:0] c, input logic o, input logic full);
      step(r, d, rd);
      @(negedge clk);
      check_out(name, v, b, t, c, o, full);
   endtask

   logic [4:0] exp_m [5];
   logic [4:0] exp_n [3];
   logic [4:0] got;

   initial begin
      reset_n  = 1'b0;
      db_level = '0;
      ev_ready = 1'b0;
      nr_ready = 1'b1;
      exp_m = '{5'b000_00, 5'b000_01, 5'b000_10, 5'b000_10, 5'b000_11};
      exp_n = '{5'b000_00, 5'b000_01, 5'b000_11};

      // Contention: four simultaneous rises, then four simultaneous falls
      tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 3'd0, 2'd0, 3'd0));
      tbl.push_back(mk(4'b1111, 1'b1, 1'b0, 3'd0, 2'd0, 3'd0));
      tbl.push_back(mk(4'b1111, 1'b1, 1'b1, 3'd0, 2'd0, 3'd1));
      tbl.push_back(mk(4'b1111, 1'b1, 1'b1, 3'd1, 2'd0, 3'd1));
      tbl.push_back(mk(4'b1111, 1'b1, 1'b1, 3'd2, 2'd0, 3'd1));
      tbl.push_back(mk(4'b1111, 1'b1, 1'b1, 3'd3, 2'd0, 3'd1));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 3'd0, 2'd0, 3'd0));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 3'd0, 2'd0, 3'd0));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b1, 3'd0, 2'd3, 3'd1));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b1, 3'd1, 2'd3, 3'd1));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b1, 3'd2, 2'd3, 3'd1));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b1, 3'd3, 2'd3, 3'd1));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 3'd0, 2'd0, 3'd0));
      // Short tap on btn1: three cycles high
      tbl.push_back(mk(4'b0010, 1'b1, 1'b0, 3'd0, 2'd0, 3'd0));
      tbl.push_back(mk(4'b0010, 1'b1, 1'b0, 3'd0, 2'd0, 3'd0));
      tbl.push_back(mk(4'b0010, 1'b1, 1'b1, 3'd1, 2'd0, 3'd1));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 3'd0, 2'd0, 3'd0));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 3'd0, 2'd0, 3'd0));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b1, 3'd1, 2'd3, 3'd1));
      tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 3'd0, 2'd0, 3'd0));

      step(1'b0, 4'b0000, 1'b1);
      step(1'b0, 4'b0000, 1'b1);
      @(negedge clk);
      check_out("reset_state", 1'b0, 3'd0, 2'd0, 3'd0, 1'b0, 1'b1);

      for (int i = 0; i < tbl.size(); i++) begin
         step(1'b1, tbl[i].db, tbl[i].rdy);
         @(negedge clk);
         check_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].btn, tbl[i].typ, tbl[i].cnt,
                   1'b0, 1'b0);
      end

      // Long hold on btn0: 20 cycles high
      step(1'b1, 4'b0001, 1'b1);
      q_main.delete();
      q_nr.delete();
      repeat (19) step(1'b1, 4'b0001, 1'b1);
      repeat (12) step(1'b1, 4'b0000, 1'b1);
      @(negedge clk);
      checks++;
      if (q_main.size() != 5) begin
         errors++;
         $display("FAIL hold_events: got %0d events, want 5", q_main.size());
      end
      for (int i = 0; i < 5; i++) begin
         got = (i < q_main.size()) ? q_main[i] : 5'h1f;
         checks++;
         if (got !== exp_m[i]) begin
            errors++;
            $display("FAIL hold_ev%0d: got btn=%0d type=%0d, want btn=%0d type=%0d",
                     i, got[4:2], got[1:0], exp_m[i][4:2], exp_m[i][1:0]);
         end
      end
      checks++;
      if (q_nr.size() != 3) begin
         errors++;
         $display("FAIL norep_events: got %0d events, want 3", q_nr.size());
      end
      for (int i = 0; i < 3; i++) begin
         got = (i < q_nr.size()) ? q_nr[i] : 5'h1f;
         checks++;
         if (got !== exp_n[i]) begin
            errors++;
            $display("FAIL norep_ev%0d: got btn=%0d type=%0d, want btn=%0d type=%0d",
                     i, got[4:2], got[1:0], exp_n[i][4:2], exp_n[i][1:0]);
         end
      end

      // Overflow: tap on btn2 plus long hold on btn3 with the consumer stalled
      step(1'b0, 4'b0000, 1'b0);
      for (int c = 0; c <= 16; c++) begin
         step(1'b1, (c < 2) ? 4'b1100 : ((c < 14) ? 4'b1000 : 4'b0000), 1'b0);
         @(negedge clk);
         if (c == 11) check_out("full_no_ovf", 1'b1, 3'd2, 2'd0, 3'd4, 1'b0, 1'b0);
         if (c == 16) check_out("full_ovf", 1'b1, 3'd2, 2'd0, 3'd4, 1'b1, 1'b0);
      end
      cyc("drain0", 1'b1, 4'b0000, 1'b1, 1'b1, 3'd2, 2'd0, 3'd4, 1'b1, 1'b0);
      cyc("pushpop_full", 1'b1, 4'b0000, 1'b1, 1'b1, 3'd3, 2'd0, 3'd4, 1'b1, 1'b0);
      cyc("drain2", 1'b1, 4'b0000, 1'b1, 1'b1, 3'd2, 2'd3, 3'd3, 1'b1, 1'b0);
      cyc("drain3", 1'b1, 4'b0000, 1'b1, 1'b1, 3'd3, 2'd1, 3'd2, 1'b1, 1'b0);
      cyc("drain4", 1'b1, 4'b0000, 1'b1, 1'b1, 3'd3, 2'd2, 3'd1, 1'b1, 1'b0);
      cyc("drained", 1'b1, 4'b0000, 1'b1, 1'b0, 3'd0, 2'd0, 3'd0, 1'b1, 1'b0);

      // Reset while btn0 is held with three events queued
      for (int h = 0; h <= 14; h++) step(1'b1, 4'b0001, 1'b0);
      @(negedge clk);
      check_out("held_queued", 1'b1, 3'd0, 2'd0, 3'd3, 1'b1, 1'b0);
      step(1'b0, 4'b0001, 1'b0);
      cyc("post_reset", 1'b1, 4'b0001, 1'b0, 1'b0, 3'd0, 2'd0, 3'd0, 1'b0, 1'b1);
      cyc("post_reset1", 1'b1, 4'b0001, 1'b0, 1'b0, 3'd0, 2'd0, 3'd0, 1'b0, 1'b0);
      cyc("repress", 1'b1, 4'b0001, 1'b0, 1'b1, 3'd0, 2'd0, 3'd1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
